// File: rtl/des_key_sched_seq_if.sv
// Key-schedule stream bundle: key load on one side,
// subkey valid/ready stream toward the round core.
interface des_key_sched_seq_if;
  logic        load;
  logic        decrypt;
  logic [63:0] key_in;
  logic        ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        done;
  logic        parity_err;

  modport master (
    output load,
    output decrypt,
    output key_in,
    output subkey_ready,
    input  ready,
    input  subkey,
    input  subkey_valid,
    input  round_idx,
    input  done,
    input  parity_err
  );

  modport slave (
    input  load,
    input  decrypt,
    input  key_in,
    input  subkey_ready,
    output ready,
    output subkey,
    output subkey_valid,
    output round_idx,
    output done,
    output parity_err
  );
endinterface

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: PC-1 once at load, C/D rotated
// in registers, PC-2 on the live C/D feeds a valid/ready stream.
module des_key_sched_seq #(
  parameter int ROUNDS       = 16,
  parameter bit PARITY_CHECK = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  des_key_sched_seq_if.slave kif
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic        mode_q;
  logic [3:0]  idx_q;
  logic        perr_q;
  logic [55:0] pc1_cd;
  logic [55:0] cd;
  logic [7:0]  byte_odd;
  logic        perr_d;
  logic        accept;
  logic        xfer;
  logic        last;
  logic [1:0]  sh_nxt;

  // Decrypt walks the encrypt table backwards; its first step is 0.
  function automatic logic [1:0] shamt(
    input logic       dec,
    input logic [3:0] i
  );
    logic [3:0] k;
    k = dec ? 4'd0 - i : i;
    if (dec && i == 4'd0) begin
      shamt = 2'd0;
    end else begin
      unique case (k)
        4'd0, 4'd1, 4'd8, 4'd15: shamt = 2'd1;
        default:                 shamt = 2'd2;
      endcase
    end
  endfunction

  function automatic logic [27:0] rot(
    input logic [27:0] v,
    input logic        right,
    input logic [1:0]  n
  );
    logic [55:0] w;
    w = {v, v};
    if (right) begin
      rot = 28'(w >> n);
    end else begin
      rot = 28'(w >> (6'd28 - {4'd0, n}));
    end
  endfunction

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_cd[55-g] = kif.key_in[64-PC1[g]];
  end

  assign cd = {c_q, d_q};

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign kif.subkey[47-g] = cd[56-PC2[g]];
  end

  for (genvar g = 0; g < 8; g++) begin : g_par
    assign byte_odd[g] = ^kif.key_in[8*g +: 8];
  end

  assign perr_d = PARITY_CHECK ? ~&byte_odd : 1'b0;

  assign accept = (state == IDLE) && kif.load;
  assign xfer   = (state == EMIT) && kif.subkey_ready;
  assign last   = (idx_q == LAST);
  assign sh_nxt = shamt(mode_q, idx_q + 4'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    kif.ready        = 1'b0;
    kif.subkey_valid = 1'b0;
    kif.done         = 1'b0;
    unique case (state)
      IDLE: begin
        kif.ready = 1'b1;
        if (kif.load) state_nxt = EMIT;
      end
      EMIT: begin
        kif.subkey_valid = 1'b1;
        if (kif.subkey_ready && last) state_nxt = FIN;
      end
      FIN: begin
        kif.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      idx_q  <= '0;
      perr_q <= 1'b0;
    end else if (accept) begin
      mode_q <= kif.decrypt;
      idx_q  <= '0;
      perr_q <= perr_d;
      c_q    <= kif.decrypt ? pc1_cd[55:28] : rot(pc1_cd[55:28], 1'b0, 2'd1);
      d_q    <= kif.decrypt ? pc1_cd[27:0]  : rot(pc1_cd[27:0],  1'b0, 2'd1);
    end else if (xfer && !last) begin
      c_q   <= rot(c_q, mode_q, sh_nxt);
      d_q   <= rot(d_q, mode_q, sh_nxt);
      idx_q <= idx_q + 4'd1;
    end
  end

  assign kif.round_idx  = idx_q;
  assign kif.parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Randomized bench for des_key_sched_seq against a bit-list
// model of the DES key schedule (cumulative-shift form).
module tb_des_key_sched_seq;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  des_key_sched_seq_if kif ();
  des_key_sched_seq_if kif4 ();

  des_key_sched_seq u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif.slave)
  );

  des_key_sched_seq #(.ROUNDS(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif4.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [47:0] ref_ks [16];
  logic [47:0] first_sk;
  logic [47:0] last_sk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ki = PC-2 of C0/D0 rotated left by the running sum of shifts.
  task automatic build_model(input logic [63:0] key);
    bit c0 [28];
    bit d0 [28];
    int tot;
    int p;
    logic [47:0] k;
    for (int j = 0; j < 28; j++) begin
      c0[j] = key[64-PC1[j]];
      d0[j] = key[64-PC1[28+j]];
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS[r];
      for (int i = 0; i < 48; i++) begin
        p = PC2[i];
        k[47-i] = (p <= 28) ? c0[(p - 1 + tot) % 28] : d0[(p - 29 + tot) % 28];
      end
      ref_ks[r] = k;
    end
  endtask

  function automatic logic exp_parity(input logic [63:0] k);
    for (int b = 0; b < 8; b++) begin
      if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // mode 0: always ready, 1: stall at idx 3 then random,
  // 2: load attempt while busy, 3: random stalls.
  task automatic run_pass(input logic [63:0] key, input bit dec, input int mode);
    int n;
    int cyc;
    int stalls;
    bit sr;
    bit prev_stall;
    logic [47:0] prev_sk;
    logic [3:0] prev_idx;
    build_model(key);
    @(negedge clk);
    check("ready_idle", kif.ready, 1);
    kif.load = 1'b1;
    kif.key_in = key;
    kif.decrypt = dec;
    kif.subkey_ready = 1'b0;
    @(posedge clk);
    #1;
    kif.load = 1'b0;
    kif.decrypt = ~dec;
    kif.key_in = {$urandom, $urandom};
    check("valid_latency", kif.subkey_valid, 1);
    check("ready_busy", kif.ready, 0);
    check("parity_err", kif.parity_err, exp_parity(key));
    n = 0;
    cyc = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev_sk = '0;
    prev_idx = '0;
    while (n < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      kif.load = (mode == 2 && n == 5);
      if (mode == 2 && n == 5) kif.key_in = 64'h0123456789ABCDEF;
      if (mode == 1 && kif.round_idx == 4'd3 && stalls < 5) begin
        sr = 1'b0;
        stalls++;
      end else if ((mode == 1 && stalls >= 5) || mode == 3) begin
        sr = bit'($urandom_range(0, 1));
      end else begin
        sr = 1'b1;
      end
      kif.subkey_ready = sr;
      check("valid", kif.subkey_valid, 1);
      if (!kif.subkey_valid) break;
      if (prev_stall) begin
        check("hold_subkey", kif.subkey, prev_sk);
        check("hold_idx", kif.round_idx, prev_idx);
      end
      if (sr) begin
        check("subkey", kif.subkey, dec ? ref_ks[15-n] : ref_ks[n]);
        check("round_idx", kif.round_idx, n[3:0]);
        if (n == 0) first_sk = kif.subkey;
        last_sk = kif.subkey;
        n++;
      end
      prev_stall = !sr;
      prev_sk = kif.subkey;
      prev_idx = kif.round_idx;
    end
    kif.load = 1'b0;
    check("transfers", n, 16);
    @(negedge clk);
    kif.subkey_ready = 1'b0;
    check("done_pulse", kif.done, 1);
    check("fin_valid", kif.subkey_valid, 0);
    check("fin_ready", kif.ready, 0);
    @(negedge clk);
    check("done_clear", kif.done, 0);
    check("ready_back", kif.ready, 1);
    check("parity_hold", kif.parity_err, exp_parity(key));
  endtask

  initial begin
    int cyc;
    logic [63:0] rk;
    kif.load = 1'b0;
    kif.decrypt = 1'b0;
    kif.key_in = '0;
    kif.subkey_ready = 1'b0;
    kif4.load = 1'b0;
    kif4.decrypt = 1'b0;
    kif4.key_in = '0;
    kif4.subkey_ready = 1'b1;
    #22;
    check("rst_ready", kif.ready, 1);
    check("rst_valid", kif.subkey_valid, 0);
    check("rst_done", kif.done, 0);
    check("rst_perr", kif.parity_err, 0);
    check("rst_idx", kif.round_idx, 0);
    check("rst_subkey", kif.subkey, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reduced-round build: K1..K4 then done.
    build_model(KEY_A);
    @(negedge clk);
    kif4.load = 1'b1;
    kif4.key_in = KEY_A;
    @(posedge clk);
    #1;
    kif4.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("r4_valid", kif4.subkey_valid, 1);
      check("r4_idx", kif4.round_idx, 4'(i));
      check("r4_subkey", kif4.subkey, ref_ks[i]);
      @(posedge clk);
      #1;
    end
    check("r4_done", kif4.done, 1);
    check("r4_fin_valid", kif4.subkey_valid, 0);
    @(posedge clk);
    #1;
    check("r4_ready", kif4.ready, 1);
    check("r4_done_clear", kif4.done, 0);

    run_pass(KEY_A, 1'b0, 0);
    check("enc_first", first_sk, K1_A);
    check("enc_last", last_sk, K16_A);
    run_pass(KEY_A, 1'b1, 0);
    check("dec_first", first_sk, K16_A);
    check("dec_last", last_sk, K1_A);
    run_pass(KEY_A, 1'b0, 1);
    run_pass(KEY_A, 1'b0, 2);
    run_pass(64'h0101010101010101, 1'b0, 0);
    check("weak_first", first_sk, 0);
    check("weak_last", last_sk, 0);

    // Asynchronous reset in the middle of the stream.
    @(negedge clk);
    kif.load = 1'b1;
    kif.key_in = KEY_A;
    kif.decrypt = 1'b0;
    kif.subkey_ready = 1'b1;
    @(posedge clk);
    #1;
    kif.load = 1'b0;
    cyc = 0;
    while (kif.round_idx != 4'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx7", kif.round_idx, 7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ready", kif.ready, 1);
    check("arst_valid", kif.subkey_valid, 0);
    check("arst_done", kif.done, 0);
    check("arst_idx", kif.round_idx, 0);
    check("arst_subkey", kif.subkey, 0);
    check("arst_perr", kif.parity_err, 0);
    kif.subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", kif.done, 0);
    end
    reset_n = 1'b1;
    run_pass(KEY_A, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom};
      run_pass(rk, bit'($urandom_range(0, 1)), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
